datapath_p2: RTL and testbench

- Single-bus 32-bit processor datapath with 16 general registers, IR-driven register select/encode logic, and an ALU feeding a 64-bit Z register.
- Also contains PC, MAR, MDR, Y, HI, LO, an I/O port pair and a branch-condition (CON) flip-flop.
- An external control unit, or a bench, sequences it through per-cycle enable strobes.
- Memory is external: read data arrives on Mdatain.

---
 rtl/datapath_p2.sv | 198 +++++++++++++++++++
 tb/tb_datapath_p2.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_p2.sv
// datapath_p2: single-bus 32-bit processor datapath.
//
// Sixteen general registers plus PC, IR, MAR, MDR, Y, HI, LO, a 64-bit Z,
// an InPort/OutPort pair and a branch-condition flip-flop. An external
// control unit sequences every transfer through per-cycle strobes.
//
// Ports
//   outp              : OutPort register contents
//   *out strobes      : bus source enables (PC, Zhi, Zlo, MDR, HI, LO, InPort)
//   *in strobes       : register load enables (MAR, Z, PC, MDR, IR, Y, HI, LO, OutPort)
//   IncPC             : ALU computes bus+1 regardless of opcode
//   Read              : MDR loads Mdatain instead of the bus
//   Write             : memory write strobe (used externally only)
//   Gra/Grb/Grc       : pick Ra/Rb/Rc field of IR as the register index
//   Rin/Rout/BAout    : write/read selected register (BAout reads R0 as 0)
//   Cout              : drive sign-extended IR constant onto the bus
//   CONIn             : latch branch condition from the bus
//   Strobe            : load InPort from InPort_data
//   Clock, Clear      : rising-edge clock, asynchronous active-low reset
//   Mdatain           : memory read data
//   InPort_data       : external input device data
module datapath_p2 (
    output logic [31:0] outp,
    input  logic        PCout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        MARin,
    input  logic        Zin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        OutPortin,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        CONIn,
    input  logic        Strobe,
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] Mdatain,
    input  logic [31:0] InPort_data
);

    logic [31:0] r_q [16];
    logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, inport_q, outport_q;
    logic [63:0] z_q;
    logic        con_q;

    logic [31:0] bus;
    logic [31:0] mdr_d;
    logic [63:0] z_d;
    logic        con_d;

    // Write strobe only matters to the external memory.
    logic unused_write;
    assign unused_write = Write;

    // IR field decode
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc, sel_idx;
    logic [31:0] c_sext;
    logic [1:0]  c2;

    assign opcode  = ir_q[31:27];
    assign ra      = ir_q[26:23];
    assign rb      = ir_q[22:19];
    assign rc      = ir_q[18:15];
    assign c_sext  = {{13{ir_q[18]}}, ir_q[18:0]};
    assign c2      = ir_q[20:19];
    assign sel_idx = (Gra ? ra : 4'd0) | (Grb ? rb : 4'd0) | (Grc ? rc : 4'd0);

    // Fixed-priority bus mux; register read beats every other source.
    always_comb begin
        bus = '0;
        if (Rout || BAout) begin
            bus = (BAout && sel_idx == 4'd0) ? 32'd0 : r_q[sel_idx];
        end else if (HIout) begin
            bus = hi_q;
        end else if (LOout) begin
            bus = lo_q;
        end else if (Zhiout) begin
            bus = z_q[63:32];
        end else if (Zlowout) begin
            bus = z_q[31:0];
        end else if (PCout) begin
            bus = pc_q;
        end else if (MDRout) begin
            bus = mdr_q;
        end else if (InPortout) begin
            bus = inport_q;
        end else if (Cout) begin
            bus = c_sext;
        end
    end

    // ALU: A = Y, B = bus
    logic signed [31:0] a_s, b_s;
    logic signed [63:0] prod;
    logic [63:0]        rot_r, rot_l;
    logic [4:0]         sh;

    assign a_s   = $signed(y_q);
    assign b_s   = $signed(bus);
    assign sh    = bus[4:0];
    assign prod  = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
    assign rot_r = {y_q, y_q} >> sh;
    assign rot_l = {y_q, y_q} << sh;

    always_comb begin
        z_d = '0;
        if (IncPC) begin
            z_d[31:0] = bus + 32'd1;
        end else begin
            case (opcode)
                5'b00011: z_d[31:0] = y_q - bus;
                5'b00101: z_d[31:0] = y_q >> sh;
                5'b00110: z_d[31:0] = 32'(a_s >>> sh);
                5'b00111: z_d[31:0] = y_q << sh;
                5'b01000: z_d[31:0] = rot_r[31:0];
                5'b01001: z_d[31:0] = rot_l[63:32];
                5'b01010,
                5'b01101: z_d[31:0] = y_q & bus;
                5'b01011,
                5'b01110: z_d[31:0] = y_q | bus;
                5'b01111: begin
                    // Divide by zero: all-ones quotient, dividend as remainder.
                    if (bus == 32'd0) begin
                        z_d = {y_q, 32'hFFFF_FFFF};
                    end else begin
                        z_d = {32'(a_s % b_s), 32'(a_s / b_s)};
                    end
                end
                5'b10000: z_d = 64'(prod);
                5'b10001: z_d[31:0] = 32'd0 - bus;
                5'b10010: z_d[31:0] = ~bus;
                default:  z_d[31:0] = y_q + bus;
            endcase
        end
    end

    assign mdr_d = Read ? Mdatain : bus;

    always_comb begin
        unique case (c2)
            2'b00: con_d = (bus == 32'd0);
            2'b01: con_d = (bus != 32'd0);
            2'b10: con_d = ~bus[31];
            2'b11: con_d = bus[31];
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            z_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            if (Rin)       r_q[sel_idx] <= bus;
            if (PCin)      pc_q         <= bus;
            if (IRin)      ir_q         <= bus;
            if (MARin)     mar_q        <= bus;
            if (MDRin)     mdr_q        <= mdr_d;
            if (Yin)       y_q          <= bus;
            if (Zin)       z_q          <= z_d;
            if (HIin)      hi_q         <= bus;
            if (LOin)      lo_q         <= bus;
            if (Strobe)    inport_q     <= InPort_data;
            if (OutPortin) outport_q    <= bus;
            if (CONIn)     con_q        <= con_d;
        end
    end

    assign outp = outport_q;

endmodule

// File: tb/tb_datapath_p2.sv
module tb_datapath_p2;

    logic [31:0] outp;
    logic PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe;
    logic Clock, Clear;
    logic [31:0] Mdatain, InPort_data;

    datapath_p2 dut (
        .outp(outp), .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .MARin(MARin), .Zin(Zin),
        .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .CONIn(CONIn), .Strobe(Strobe), .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain),
        .InPort_data(InPort_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_run = 0;
    int n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic clr_ctl();
        {PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin} = '0;
        {IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONIn, Strobe} = '0;
    endtask

    // Inputs change at negedge; results settled by the following negedge.
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
        clr_ctl();
    endtask

    task automatic put_inport(input logic [31:0] v);
        Strobe = 1; InPort_data = v; tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        put_inport(v); InPortout = 1; IRin = 1; tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        put_inport(v); InPortout = 1; Yin = 1; tick();
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
        load_ir(mk_ir(5'd0, idx, 4'd0, 4'd0));
        put_inport(v); InPortout = 1; Gra = 1; Rin = 1; tick();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        load_ir(mk_ir(op, 4'd0, 4'd0, 4'd0));
        load_y(a);
        put_inport(b); InPortout = 1; Zin = 1; tick();
    endtask

    task automatic dump_zlo();
        Zlowout = 1; OutPortin = 1; tick();
    endtask

    task automatic dump_zhi();
        Zhiout = 1; OutPortin = 1; tick();
    endtask

    task automatic test_reset();
        clr_ctl(); Mdatain = '0; InPort_data = '0; Clear = 1'b0;
        #3;
        n_run++;
        if (outp !== 32'd0) begin n_fail++; $display("FAIL reset_outp: got %h want %h", outp, 32'd0); end
        @(negedge Clock); @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        exp_q.push_back(32'd0);
        PCout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL reset_pc: got %h want %h", outp, e); end
        exp_q.push_back(32'd0);
        dump_zlo();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL reset_zlo: got %h want %h", outp, e); end
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h0080_0055; tick();
        MDRout = 1; IRin = 1; tick();
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_run++;
        if (dut.mar_q !== e) begin n_fail++; $display("FAIL fetch_mar: got %h want %h", dut.mar_q, e); end
        exp_q.push_back(32'h0080_0055);
        e = exp_q.pop_front(); n_run++;
        if (dut.ir_q !== e) begin n_fail++; $display("FAIL fetch_ir: got %h want %h", dut.ir_q, e); end
        exp_q.push_back(32'd1);
        PCout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL fetch_pc: got %h want %h", outp, e); end
    endtask

    task automatic test_ld();
        Grb = 1; BAout = 1; Yin = 1; tick();
        Cout = 1; Zin = 1; tick();
        Zlowout = 1; MARin = 1; tick();
        Read = 1; MDRin = 1; Mdatain = 32'h1234_5678; tick();
        MDRout = 1; Gra = 1; Rin = 1; tick();
        exp_q.push_back(32'h55);
        e = exp_q.pop_front(); n_run++;
        if (dut.mar_q !== e) begin n_fail++; $display("FAIL ld_mar: got %h want %h", dut.mar_q, e); end
        exp_q.push_back(32'h1234_5678);
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL ld_r1: got %h want %h", outp, e); end
    endtask

    task automatic test_add_sub();
        logic [4:0] ops [2];
        logic [31:0] res [2];
        ops[0] = 5'b00100; res[0] = 32'd12;
        ops[1] = 5'b00011; res[1] = 32'd2;
        load_reg(4'd2, 32'd7);
        load_reg(4'd3, 32'd5);
        for (int i = 0; i < 2; i++) begin
            load_ir(mk_ir(ops[i], 4'd0, 4'd2, 4'd3));
            Grb = 1; Rout = 1; Yin = 1; tick();
            Grc = 1; Rout = 1; Zin = 1; tick();
            exp_q.push_back(res[i]);
            exp_q.push_back(32'd0);
            dump_zlo();
            e = exp_q.pop_front(); n_run++;
            if (outp !== e) begin n_fail++; $display("FAIL addsub_lo[%0d]: got %h want %h", i, outp, e); end
            dump_zhi();
            e = exp_q.pop_front(); n_run++;
            if (outp !== e) begin n_fail++; $display("FAIL addsub_hi[%0d]: got %h want %h", i, outp, e); end
        end
    endtask

    task automatic test_alu_table();
        vec_t v [$];
        v.push_back(vec_t'{5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'd0});
        v.push_back(vec_t'{5'b00110, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'd0});
        v.push_back(vec_t'{5'b00111, 32'd3, 32'h21, 32'd6, 32'd0});
        v.push_back(vec_t'{5'b01000, 32'd1, 32'd1, 32'h8000_0000, 32'd0});
        v.push_back(vec_t'{5'b01001, 32'h8000_0000, 32'd1, 32'd1, 32'd0});
        v.push_back(vec_t'{5'b01010, 32'hF0F0, 32'hFF00, 32'hF000, 32'd0});
        v.push_back(vec_t'{5'b01101, 32'hF0F0, 32'hFF00, 32'hF000, 32'd0});
        v.push_back(vec_t'{5'b01011, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'd0});
        v.push_back(vec_t'{5'b01110, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'd0});
        v.push_back(vec_t'{5'b10001, 32'd9, 32'd1, 32'hFFFF_FFFF, 32'd0});
        v.push_back(vec_t'{5'b10010, 32'd9, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'd0});
        v.push_back(vec_t'{5'b10000, 32'hFFFF_FFFA, 32'd4, 32'hFFFF_FFE8, 32'hFFFF_FFFF});
        v.push_back(vec_t'{5'b10000, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1});
        v.push_back(vec_t'{5'b01111, 32'hFFFF_FFFA, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        v.push_back(vec_t'{5'b01111, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234});
        v.push_back(vec_t'{5'b00100, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0});
        v.push_back(vec_t'{5'b00011, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0});
        v.push_back(vec_t'{5'b00000, 32'd3, 32'd4, 32'd7, 32'd0});
        foreach (v[i]) begin
            alu_op(v[i].op, v[i].a, v[i].b);
            exp_q.push_back(v[i].lo);
            exp_q.push_back(v[i].hi);
            dump_zlo();
            e = exp_q.pop_front(); n_run++;
            if (outp !== e) begin
                n_fail++; $display("FAIL alu_lo op=%b: got %h want %h", v[i].op, outp, e);
            end
            dump_zhi();
            e = exp_q.pop_front(); n_run++;
            if (outp !== e) begin
                n_fail++; $display("FAIL alu_hi op=%b: got %h want %h", v[i].op, outp, e);
            end
        end
    endtask

    task automatic test_incpc();
        load_ir(mk_ir(5'b00011, 4'd0, 4'd0, 4'd0));
        load_y(32'd5);
        put_inport(32'd9); InPortout = 1; IncPC = 1; Zin = 1; tick();
        exp_q.push_back(32'd10);
        dump_zlo();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL incpc_override: got %h want %h", outp, e); end
    endtask

    task automatic test_priority();
        load_reg(4'd0, 32'h77);
        exp_q.push_back(32'd0);
        Gra = 1; BAout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL baout_r0: got %h want %h", outp, e); end
        exp_q.push_back(32'h77);
        Gra = 1; Rout = 1; HIout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL rout_r0: got %h want %h", outp, e); end
        put_inport(32'h1111); InPortout = 1; HIin = 1; tick();
        put_inport(32'h2222); InPortout = 1; LOin = 1; tick();
        exp_q.push_back(32'h1111);
        HIout = 1; LOout = 1; Zlowout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL prio_hi: got %h want %h", outp, e); end
        exp_q.push_back(32'h2222);
        LOout = 1; PCout = 1; InPortout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL prio_lo: got %h want %h", outp, e); end
        // Z drives the bus and reloads in the same cycle.
        put_inport(32'h40); InPortout = 1; PCin = 1; tick();
        PCout = 1; IncPC = 1; Zin = 1; tick();
        Zlowout = 1; IncPC = 1; Zin = 1; tick();
        exp_q.push_back(32'h42);
        dump_zlo();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL z_self_load: got %h want %h", outp, e); end
    endtask

    task automatic test_io_con();
        logic [1:0]  cs [7];
        logic [31:0] bv [7];
        logic        cx [7];
        cs = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
        bv = '{32'd0, 32'd0, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd1};
        cx = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        put_inport(32'hA5);
        exp_q.push_back(32'hA5);
        InPortout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL io_outp: got %h want %h", outp, e); end
        for (int i = 0; i < 7; i++) begin
            load_ir({11'd0, cs[i], 19'd0});
            put_inport(bv[i]);
            if (bv[i] != 32'd0) InPortout = 1;
            CONIn = 1; tick();
            exp_q.push_back({31'd0, cx[i]});
            e = exp_q.pop_front(); n_run++;
            if ({31'd0, dut.con_q} !== e) begin
                n_fail++; $display("FAIL con[%0d]: got %b want %b", i, dut.con_q, e[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        put_inport(32'h5A); InPortout = 1; OutPortin = 1; tick();
        exp_q.push_back(32'h5A);
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL pre_reset_outp: got %h want %h", outp, e); end
        #2 Clear = 1'b0;
        #1;
        n_run++;
        if (outp !== 32'd0) begin n_fail++; $display("FAIL async_reset: got %h want %h", outp, 32'd0); end
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
        load_ir(mk_ir(5'd0, 4'd1, 4'd0, 4'd0));
        exp_q.push_back(32'd0);
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL reset_r1: got %h want %h", outp, e); end
        exp_q.push_back(32'd0);
        dump_zhi();
        e = exp_q.pop_front(); n_run++;
        if (outp !== e) begin n_fail++; $display("FAIL reset_zhi: got %h want %h", outp, e); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_ld();
        test_add_sub();
        test_alu_table();
        test_incpc();
        test_priority();
        test_io_con();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
